// File: rtl/delay_seq_scheduler.sv
// Four-channel delay-table player: each channel fetches its delay words over one shared,
// round-robin arbitrated RAM read port and fires once per entry. Loop playback: DELAY_SEQ_LOOP_EN.
module delay_seq_scheduler #(
  parameter int ADDR_W = 11,
  parameter int DLY_W  = 24,
  parameter int RD_LAT = 2   // read latency in cycles, 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_TRIG,
  input  logic              I_ABORT,
`ifdef DELAY_SEQ_LOOP_EN
  input  logic              I_LOOP,
`endif
  input  logic [ADDR_W-1:0] I_LEN_RAM1,
  input  logic [ADDR_W-1:0] I_LEN_RAM2,
  input  logic [ADDR_W-1:0] I_LEN_RAM3,
  input  logic [ADDR_W-1:0] I_LEN_RAM4,
  output logic              O_RD_EN,
  output logic [1:0]        O_RD_SEL,
  output logic [ADDR_W-1:0] O_RD_ADDR,
  input  logic [DLY_W-1:0]  I_RD_DATA,
  output logic [3:0]        O_FIRE,
  output logic [3:0]        O_BUSY,
  output logic              O_SEQ_DONE
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_COUNT, S_DONE} ch_state_e;

  ch_state_e         state_q [4];
  ch_state_e         state_d [4];
  logic [ADDR_W-1:0] addr_q  [4];
  logic [ADDR_W-1:0] addr_d  [4];
  logic [ADDR_W-1:0] len_q   [4];
  logic [ADDR_W-1:0] len_d   [4];
  logic [ADDR_W-1:0] len_in  [4];
  logic [DLY_W-1:0]  cnt_q   [4];
  logic [DLY_W-1:0]  cnt_d   [4];
  logic [1:0]        rr_q, rr_d;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [1:0]        tag_id_q [RD_LAT];
  logic              loop_q, loop_d;
  logic              empty_done_q, empty_done_d;
  logic              trig_ok, all_empty, grant, in_flight, cap_vld;
  logic [1:0]        grant_id, cap_id;
  logic [3:0]        finish;

  assign len_in[0] = I_LEN_RAM1;
  assign len_in[1] = I_LEN_RAM2;
  assign len_in[2] = I_LEN_RAM3;
  assign len_in[3] = I_LEN_RAM4;

  assign in_flight = |tag_vld_q;
  assign cap_vld   = tag_vld_q[RD_LAT-1];
  assign cap_id    = tag_id_q[RD_LAT-1];

  // Busy flags and the round-robin grant: search starts one past the last granted channel.
  always_comb begin
    grant    = 1'b0;
    grant_id = rr_q;
    for (int c = 0; c < 4; c++) begin
      O_BUSY[c] = (state_q[c] != S_IDLE) && (state_q[c] != S_DONE);
    end
    for (int k = 1; k <= 4; k++) begin
      if (!grant && !in_flight && state_q[rr_q + 2'(k)] == S_FETCH) begin
        grant    = 1'b1;
        grant_id = rr_q + 2'(k);
      end
    end
  end

  assign O_RD_EN   = grant;
  assign O_RD_SEL  = grant ? grant_id : 2'd0;
  assign O_RD_ADDR = grant ? addr_q[grant_id] : '0;

  assign all_empty = (len_in[0] == '0) && (len_in[1] == '0) && (len_in[2] == '0) && (len_in[3] == '0);
  assign trig_ok   = I_TRIG && !I_ABORT && (O_BUSY == 4'b0000);

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    rr_d         = grant ? grant_id : rr_q;
`ifdef DELAY_SEQ_LOOP_EN
    loop_d       = trig_ok ? I_LOOP : loop_q;
`else
    loop_d       = 1'b0;
`endif
    empty_done_d = trig_ok && all_empty && !loop_d;
    O_FIRE       = '0;
    finish       = '0;
    for (int c = 0; c < 4; c++) begin
      state_d[c] = state_q[c];
      addr_d[c]  = addr_q[c];
      len_d[c]   = len_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        S_FETCH: if (grant && grant_id == 2'(c)) state_d[c] = S_WAIT;
        S_WAIT: begin
          if (cap_vld && cap_id == 2'(c)) begin
            cnt_d[c]   = I_RD_DATA;
            state_d[c] = S_COUNT;
          end
        end
        S_COUNT: begin
          if (cnt_q[c] == '0) begin
            O_FIRE[c] = 1'b1;
            if (addr_q[c] != len_q[c]) begin
              addr_d[c]  = addr_q[c] + ADDR_W'(1);
              state_d[c] = S_FETCH;
            end else if (loop_q) begin
              addr_d[c]  = ADDR_W'(1);
              state_d[c] = S_FETCH;
            end else begin
              state_d[c] = S_DONE;
              finish[c]  = 1'b1;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - DLY_W'(1);
          end
        end
        default: ;
      endcase
      if (trig_ok) begin
        len_d[c]   = len_in[c];
        addr_d[c]  = ADDR_W'(1);
        state_d[c] = (len_in[c] != '0) ? S_FETCH : S_DONE;
      end
      if (I_ABORT) state_d[c] = S_IDLE;
    end
  end

  // The sequence ends when something finishes and no other channel is left busy.
  assign O_SEQ_DONE = empty_done_q || ((finish != 4'b0000) && ((O_BUSY & ~finish) == 4'b0000));

  // NOTE: the tag pipe is a handful of flops, so it is reset like any other state; abort flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        state_q[c] <= S_IDLE;
        addr_q[c]  <= '0;
        len_q[c]   <= '0;
        cnt_q[c]   <= '0;
      end
      for (int k = 0; k < RD_LAT; k++) tag_id_q[k] <= '0;
      tag_vld_q    <= '0;
      rr_q         <= 2'd3;
      loop_q       <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        state_q[c] <= state_d[c];
        addr_q[c]  <= addr_d[c];
        len_q[c]   <= len_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      tag_vld_q[0] <= grant && !I_ABORT;
      tag_id_q[0]  <= grant_id;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1] && !I_ABORT;
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      rr_q         <= rr_d;
      loop_q       <= loop_d;
      empty_done_q <= empty_done_d;
    end
  end

endmodule

// File: tb/tb_delay_seq_scheduler.sv
// Self-checking bench for delay_seq_scheduler: RAM bank model, event-level reference
// schedule, hand-derived vector table and corner sequences (loop test under DELAY_SEQ_LOOP_EN).
module tb_delay_seq_scheduler;
  localparam int ADDR_W = 11;
  localparam int DLY_W  = 24;
  localparam int RD_LAT = 2;
  localparam int MAXC   = 8400;

  logic              clk = 1'b0;
  logic              rst_n, I_TRIG, I_ABORT;
  logic [ADDR_W-1:0] I_LEN_RAM1, I_LEN_RAM2, I_LEN_RAM3, I_LEN_RAM4;
  logic              O_RD_EN;
  logic [1:0]        O_RD_SEL;
  logic [ADDR_W-1:0] O_RD_ADDR;
  logic [DLY_W-1:0]  I_RD_DATA;
  logic [3:0]        O_FIRE, O_BUSY;
  logic              O_SEQ_DONE;
`ifdef DELAY_SEQ_LOOP_EN
  logic              I_LOOP;
`endif

  delay_seq_scheduler #(.ADDR_W(ADDR_W), .DLY_W(DLY_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .I_TRIG(I_TRIG), .I_ABORT(I_ABORT),
`ifdef DELAY_SEQ_LOOP_EN
    .I_LOOP(I_LOOP),
`endif
    .I_LEN_RAM1(I_LEN_RAM1), .I_LEN_RAM2(I_LEN_RAM2), .I_LEN_RAM3(I_LEN_RAM3), .I_LEN_RAM4(I_LEN_RAM4),
    .O_RD_EN(O_RD_EN), .O_RD_SEL(O_RD_SEL), .O_RD_ADDR(O_RD_ADDR), .I_RD_DATA(I_RD_DATA),
    .O_FIRE(O_FIRE), .O_BUSY(O_BUSY), .O_SEQ_DONE(O_SEQ_DONE)
  );

  always #5 clk = ~clk;

  // RAM bank: data appears RD_LAT cycles after the strobe, junk otherwise.
  logic [DLY_W-1:0] ram     [4][2048];
  logic [DLY_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= O_RD_EN ? ram[O_RD_SEL][O_RD_ADDR] : 24'hBADBAD;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign I_RD_DATA = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic              en;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        fire;
    logic [3:0]        busy;
    logic              done;
  } out_t;

  typedef struct {
    logic [3:0][ADDR_W-1:0] len;
    logic [3:0][31:0]       dly;       // byte e-1 of dly[ch] = delay of entry e
    int                     exp_done;
    logic [15:0]            exp_fires; // fire count per channel, one nibble each
    int                     exp_nreads;
    int                     exp_last_cyc;
  } vec_t;

  out_t                   exp_tab [MAXC];
  vec_t                   vecs [5];
  int                     n_checks = 0, n_err = 0;
  int                     model_ptr = 3, model_end;
  int                     done_cnt, done_cyc, bad_addr, nrd, bad, quiet;
  logic [3:0][3:0]        fire_cnt;
  int                     read_addr [$];
  int                     read_cyc  [$];
  logic [3:0][ADDR_W-1:0] l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic out_t outs();
    return {O_RD_EN, O_RD_SEL, O_RD_ADDR, O_FIRE, O_BUSY, O_SEQ_DONE};
  endfunction

  // Event-level schedule: a channel is ready to read at some cycle, the port is free again
  // RD_LAT+1 cycles after a grant, and an entry fires RD_LAT+1+delay cycles after its grant.
  task automatic build_model(input logic [3:0][ADDR_W-1:0] len);
    int ready[4], nxt[4], fin[4];
    int bus_free, t, ch, c, fire, last;
    for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
    bus_free = 1;
    for (int k = 0; k < 4; k++) begin
      ready[k] = (len[k] != 0) ? 1 : -1;
      nxt[k]   = 1;
      fin[k]   = 0;
    end
    forever begin
      t = -1;
      for (int k = 0; k < 4; k++) if (ready[k] >= 0 && (t < 0 || ready[k] < t)) t = ready[k];
      if (t < 0) break;
      if (bus_free > t) t = bus_free;
      ch = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (model_ptr + k) % 4;
        if (ch < 0 && ready[c] >= 0 && ready[c] <= t) ch = c;
      end
      exp_tab[t].en   = 1'b1;
      exp_tab[t].sel  = 2'(ch);
      exp_tab[t].addr = ADDR_W'(nxt[ch]);
      fire = t + RD_LAT + 1 + int'(ram[ch][nxt[ch]]);
      exp_tab[fire].fire[ch] = 1'b1;
      bus_free  = t + RD_LAT + 1;
      model_ptr = ch;
      if (nxt[ch] == int'(len[ch])) begin
        ready[ch] = -1;
        fin[ch]   = fire;
      end else begin
        nxt[ch]++;
        ready[ch] = fire + 1;
      end
    end
    last = 0;
    for (int k = 0; k < 4; k++) begin
      if (len[k] != 0) begin
        for (int i = 1; i <= fin[k]; i++) exp_tab[i].busy[k] = 1'b1;
        if (fin[k] > last) last = fin[k];
      end
    end
    model_end = (last > 0) ? last : 1;
    exp_tab[model_end].done = 1'b1;
  endtask

  // Called at a falling edge: that cycle is the trigger cycle 0. mode 1 re-triggers at cycle 2,
  // mode 2 re-triggers in the O_SEQ_DONE cycle; mutate scrambles the LEN inputs after the trigger.
  task automatic run_seq(input logic [3:0][ADDR_W-1:0] len, input int mode, input bit mutate);
    int win, retrig_at;
    build_model(len);
    win       = model_end + 4;
    retrig_at = (len == '0) ? -1 : (mode == 1) ? 2 : (mode == 2) ? model_end : -1;
    done_cnt = 0; done_cyc = -1; bad_addr = 0; fire_cnt = '0;
    read_addr.delete(); read_cyc.delete();
    I_LEN_RAM1 = len[0]; I_LEN_RAM2 = len[1]; I_LEN_RAM3 = len[2]; I_LEN_RAM4 = len[3];
    I_TRIG = 1'b1;
    @(negedge clk);
    I_TRIG = 1'b0;
    for (int c = 1; c <= win; c++) begin
      check($sformatf("cyc%0d", c), outs(), exp_tab[c]);
      if (O_SEQ_DONE) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (O_RD_EN) begin
        read_addr.push_back(int'(O_RD_ADDR));
        read_cyc.push_back(c);
        if (O_RD_ADDR == '0 || O_RD_ADDR > len[O_RD_SEL]) bad_addr++;
      end
      for (int k = 0; k < 4; k++) if (O_FIRE[k]) fire_cnt[k] = fire_cnt[k] + 4'd1;
      I_TRIG = (c == retrig_at);
      if (mutate) begin
        I_LEN_RAM1 = ADDR_W'($urandom); I_LEN_RAM2 = ADDR_W'($urandom);
        I_LEN_RAM3 = ADDR_W'($urandom); I_LEN_RAM4 = ADDR_W'($urandom);
      end
      @(negedge clk);
    end
    I_TRIG = 1'b0;
    check("addr_range", bad_addr, 0);
    check("seq_done_count", done_cnt, 1);
  endtask

  initial begin
    rst_n = 1'b0; I_TRIG = 1'b0; I_ABORT = 1'b0;
    I_LEN_RAM1 = '0; I_LEN_RAM2 = '0; I_LEN_RAM3 = '0; I_LEN_RAM4 = '0;
`ifdef DELAY_SEQ_LOOP_EN
    I_LOOP = 1'b0;
`endif
    for (int ch = 0; ch < 4; ch++) for (int a = 0; a < 2048; a++) ram[ch][a] = '0;

    vecs[0] = '{{11'd1, 11'd1, 11'd1, 11'd1}, 128'h0, 13, 16'h1111, 4, 10};
    vecs[1] = '{{11'd1, 11'd0, 11'd0, 11'd2}, {32'h1, 32'h0, 32'h0, 32'h3}, 11, 16'h1002, 3, 8};
    vecs[2] = '{{11'd0, 11'd0, 11'd0, 11'd1}, {32'h0, 32'h0, 32'h0, 32'h5}, 9, 16'h0001, 1, 1};
    vecs[3] = '{{11'd0, 11'd0, 11'd3, 11'd0}, {32'h0, 32'h0, 32'h00010200, 32'h0}, 15, 16'h0030, 3, 11};
    vecs[4] = '{{11'd0, 11'd0, 11'd0, 11'd0}, 128'h0, 1, 16'h0000, 0, -1};

    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", outs(), '0);

    // Hand-derived scenarios; order matters because the arbiter pointer carries over.
    for (int i = 0; i < 5; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int a = 0; a < 6; a++) begin
          ram[ch][a] = '0;
          if (a >= 1 && a <= 4) ram[ch][a] = DLY_W'(vecs[i].dly[ch][8*(a-1) +: 8]);
        end
      end
      run_seq(vecs[i].len, 0, 1'b0);
      check($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_fires", i), fire_cnt, vecs[i].exp_fires);
      check($sformatf("v%0d_nreads", i), read_addr.size(), vecs[i].exp_nreads);
      check($sformatf("v%0d_last_read", i), (read_cyc.size() > 0) ? read_cyc[$] : -1, vecs[i].exp_last_cyc);
    end

    // Abort one cycle after the second grant, then re-trigger straight away.
    l = '0; l[0] = 11'd2; ram[0][1] = '0; ram[0][2] = '0;
    I_LEN_RAM1 = l[0]; I_LEN_RAM2 = '0; I_LEN_RAM3 = '0; I_LEN_RAM4 = '0;
    I_TRIG = 1'b1;
    @(negedge clk);
    I_TRIG = 1'b0;
    check("abort_first_grant", {O_RD_EN, O_RD_SEL, O_RD_ADDR}, {1'b1, 2'd0, 11'd1});
    repeat (4) @(negedge clk);
    check("abort_second_grant", {O_RD_EN, O_RD_SEL, O_RD_ADDR}, {1'b1, 2'd0, 11'd2});
    @(negedge clk);
    I_ABORT = 1'b1;
    @(negedge clk);
    I_ABORT = 1'b0;
    quiet = 0;
    for (int c = 7; c <= 12; c++) begin
      if (outs() != '0) quiet++;
      @(negedge clk);
    end
    check("abort_quiet", quiet, 0);
    model_ptr = 0;
    run_seq(l, 0, 1'b0);

    // Trigger together with abort while idle: dropped.
    I_TRIG = 1'b1; I_ABORT = 1'b1;
    @(negedge clk);
    I_TRIG = 1'b0; I_ABORT = 1'b0;
    quiet = 0;
    repeat (5) begin
      if (outs() != '0) quiet++;
      @(negedge clk);
    end
    check("trig_abort_dropped", quiet, 0);

    // Asynchronous reset in the middle of a count.
    l = '0; l[0] = 11'd1; ram[0][1] = 24'd20;
    I_LEN_RAM1 = l[0];
    I_TRIG = 1'b1;
    @(negedge clk);
    I_TRIG = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", O_BUSY, 4'b0001);
    #2 rst_n = 1'b0;
    #1 check("async_rst_out", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (25) begin
      if (outs() != '0) quiet++;
      @(negedge clk);
    end
    check("after_rst_quiet", quiet, 0);
    model_ptr = 3;

    // Randomized tables, re-triggers while busy and LEN changes after the trigger.
    for (int r = 0; r < 20; r++) begin
      for (int ch = 0; ch < 4; ch++) begin
        l[ch] = ADDR_W'($urandom_range(0, 4));
        for (int a = 0; a < 6; a++) ram[ch][a] = DLY_W'($urandom_range(0, 7));
      end
      run_seq(l, r % 3, (r % 2) == 1);
    end

    // Largest legal table on channel 0.
    l = '0; l[0] = 11'd2047;
    for (int a = 1; a < 2048; a++) ram[0][a] = '0;
    run_seq(l, 0, 1'b0);
    check("max_len_done_cyc", done_cyc, 8188);
    check("max_len_nreads", read_addr.size(), 2047);
    check("max_len_last_addr", read_addr[$], 2047);

`ifdef DELAY_SEQ_LOOP_EN
    l = '0; l[3] = 11'd2; ram[3][1] = 24'd1; ram[3][2] = 24'd2;
    I_LEN_RAM1 = '0; I_LEN_RAM2 = '0; I_LEN_RAM3 = '0; I_LEN_RAM4 = l[3];
    I_LOOP = 1'b1; I_TRIG = 1'b1;
    @(negedge clk);
    I_LOOP = 1'b0; I_TRIG = 1'b0;
    nrd = 0; bad = 0; done_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      if (O_RD_EN) begin
        if (O_RD_SEL != 2'd3 || int'(O_RD_ADDR) != (nrd % 2) + 1) bad++;
        nrd++;
      end
      if (O_SEQ_DONE) done_cnt++;
      @(negedge clk);
    end
    check("loop_addr_seq", bad, 0);
    check("loop_reads", nrd >= 6, 1);
    check("loop_no_done", done_cnt, 0);
    check("loop_busy", O_BUSY, 4'b1000);
    I_ABORT = 1'b1;
    @(negedge clk);
    I_ABORT = 1'b0;
    check("loop_abort_idle", outs(), '0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_seq_scheduler.md
Name: delay_seq_scheduler

Overview:
- Plays back the per-port delay tables that the UART receive path writes into the four delay RAMs (RAM1-RAM4, ports 0-3).
- On a trigger, each of four channels steps through its table and emits one fire pulse per entry after that entry's programmed delay.
- All channels share one read path into the RAM bank; a round-robin arbiter grants it with at most one read in flight.
- Sits between the delay RAMs and the waveform-start logic.

Parameters:
- ADDR_W, 11: RAM address width; matches the write-address counters.
- DLY_W, 24: delay word width, in clk cycles.
- RD_LAT, 2: cycles from O_RD_EN to valid I_RD_DATA. Legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- I_TRIG  in  1  single-cycle start pulse for all channels.
- I_ABORT  in  1  single-cycle stop pulse for all channels.
- I_LEN_RAM1..I_LEN_RAM4  in  ADDR_W each  last valid address of each table. Entries occupy addresses 1..LEN; LEN=0 means empty.
- O_RD_EN  out  1  read strobe to the RAM bank.
- O_RD_SEL  out  2  RAM select for the read (0..3 = RAM1..RAM4).
- O_RD_ADDR  out  ADDR_W  read address.
- I_RD_DATA  in  DLY_W  read data, valid RD_LAT cycles after O_RD_EN.
- O_FIRE  out  4  one-cycle fire pulse per channel.
- O_BUSY  out  4  channel active (any state other than IDLE or DONE).
- O_SEQ_DONE  out  1  one-cycle pulse when the last busy channel finishes.

Behaviour:
- Reset values: O_RD_EN=0, O_RD_SEL=0, O_RD_ADDR=0, O_FIRE=0, O_BUSY=0, O_SEQ_DONE=0. All channels IDLE, round-robin pointer=3 (ch0 has first priority), in-flight tag pipe cleared.
- Per-channel states: IDLE, FETCH, WAIT, COUNT, DONE.
- Trigger:
  - I_TRIG in cycle T, with no channel busy: each channel latches its LEN.
  - Channels with LEN!=0 enter FETCH at T+1 with addr=1.
  - Channels with LEN=0 go to DONE.
  - If all LEN=0, O_SEQ_DONE pulses at T+1.
  - I_TRIG while any O_BUSY bit is set is ignored.
- Arbiter:
  - When no read is in flight, grant the first FETCH channel after the pointer, in round-robin order.
  - In the grant cycle: O_RD_EN=1, O_RD_SEL=channel, O_RD_ADDR=channel addr. Pointer updates to the granted channel; that channel moves to WAIT.
  - A tag pipe (valid + 2-bit channel id, depth RD_LAT) marks the returning data.
  - The next grant is allowed no earlier than the cycle after capture.
- Capture:
  - In cycle G+RD_LAT (G = grant cycle), I_RD_DATA loads the channel's DLY_W counter; the channel enters COUNT at G+RD_LAT+1.
- COUNT:
  - counter==0: assert O_FIRE[ch] for that cycle. Then addr==LEN goes to DONE; otherwise addr+1 and back to FETCH.
  - counter!=0: decrement.
  - Fire cycle = G+RD_LAT+1+D. D=0 fires immediately on COUNT entry.
  - The delay is counted from capture, not from the previous fire; arbitration wait is not compensated.
- DONE:
  - O_BUSY[ch]=0.
  - O_SEQ_DONE pulses in the cycle the last busy channel leaves COUNT.
  - Several channels finishing in the same cycle give a single pulse.
- Abort:
  - I_ABORT sends all channels to IDLE next cycle and clears the tag pipe, so any in-flight read return is ignored.
  - No O_FIRE or O_SEQ_DONE is produced from the abort.
  - I_ABORT and I_TRIG in the same cycle: abort wins, trigger dropped.
- LEN input changes after the trigger have no effect until the next trigger.
- Address wrap: addr never exceeds the latched LEN. LEN=2^ADDR_W-1 is legal.
- Asynchronous reset mid-sequence: immediate return to reset values; no pulses.

Optional Feature:
- Macro DELAY_SEQ_LOOP_EN.
- When defined, an extra input I_LOOP (1 bit) is added, sampled at trigger.
  - With I_LOOP=1, a channel at addr==LEN wraps to addr=1 and FETCH instead of DONE; it runs until I_ABORT.
  - O_SEQ_DONE never pulses in loop mode.
- When undefined, the port is absent and behaviour is as above.

Test Plan:
1. RD_LAT=2; LEN_RAM1=1, others 0; RAM1[1]=5; I_TRIG at cycle 0.
   -> O_RD_EN with sel 0, addr 1 at cycle 1; O_FIRE[0] at cycle 9; O_SEQ_DONE at cycle 9; O_BUSY=0 from cycle 10.
2. All LEN=1, all delays 0, trigger at cycle 0.
   -> grants ch0/ch1/ch2/ch3 at cycles 1/4/7/10; fires at 4/7/10/13; one O_SEQ_DONE at 13.
3. LEN_RAM2=3, delays {0,2,1}.
   -> reads addr 1,2,3 on sel 1 in order; three O_FIRE[1] pulses; no read at addr 4 or 0.
4. I_ABORT one cycle after a grant.
   -> returning data ignored; no O_FIRE; O_BUSY=0 next cycle. An immediate re-trigger starts cleanly at addr 1.
5. I_TRIG while busy, and I_TRIG+I_ABORT in the same cycle.
   -> both triggers ignored; the running sequence is unaffected in the first case.
6. With DELAY_SEQ_LOOP_EN defined, I_LOOP=1, LEN_RAM4=2.
   -> addresses 1,2,1,2,... on sel 3; no O_SEQ_DONE until aborted.
